// File: rtl/mcu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mcu_pkg : opcodes, state encodings and control codes for mcu_fsm     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mcu_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcWr;
        logic       pcWrCond;
        logic       branchNe;
        logic       iord;
        logic       memRd;
        logic       memWr;
        logic       irWr;
        logic       memToReg;
        logic [1:0] pcSrc;
        logic [1:0] aluOp;
        logic [1:0] aluSrcB;
        logic       aluSrcA;
        logic       regWr;
        logic       regDst;
        logic       illegalOp;
        logic       instrDone;
    } ctrl_t;

    // Disabled optional opcodes fall through to the illegal path.
    function automatic logic op_legal(input logic [5:0] op, input logic enAddi, input logic enBne);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
            OP_BNE:                           op_legal = enBne;
            OP_ADDI:                          op_legal = enAddi;
            default:                          op_legal = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcu_fsm_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mcu_fsm_if : controller <-> multicycle datapath signal bundle        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mcu_fsm_if #(
    parameter int STATE_W = 4
) ();
    logic [5:0]         op_code;
    logic               mem_ready;
    logic               pc_wr;
    logic               pc_wr_cond;
    logic               branch_ne;
    logic               iord;
    logic               mem_rd;
    logic               mem_wr;
    logic               ir_wr;
    logic               mem_to_reg;
    logic [1:0]         pc_src;
    logic [1:0]         alu_op;
    logic [1:0]         alu_src_b;
    logic               alu_src_a;
    logic               reg_wr;
    logic               reg_dst;
    logic               illegal_op;
    logic               instr_done;
    logic [STATE_W-1:0] state;

    modport master (
        input  op_code, mem_ready,
        output pc_wr, pc_wr_cond, branch_ne, iord, mem_rd, mem_wr, ir_wr,
               mem_to_reg, pc_src, alu_op, alu_src_b, alu_src_a, reg_wr,
               reg_dst, illegal_op, instr_done, state
    );

    modport slave (
        output op_code, mem_ready,
        input  pc_wr, pc_wr_cond, branch_ne, iord, mem_rd, mem_wr, ir_wr,
               mem_to_reg, pc_src, alu_op, alu_src_b, alu_src_a, reg_wr,
               reg_dst, illegal_op, instr_done, state
    );
endinterface
`default_nettype wire

// File: rtl/mcu_out_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mcu_out_decode : state (+mem_ready, opcode legality) -> controls     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mcu_out_decode
    import mcu_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  wire logic [STATE_W-1:0] i_state,
    input  wire logic               i_memReady,
    input  wire logic               i_legal,
    input  wire logic               i_isBne,
    output ctrl_t                   o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            STATE_W'(S_FETCH): begin
                o_ctrl.memRd   = 1'b1;
                o_ctrl.aluSrcB = SRCB_FOUR;
                o_ctrl.irWr    = i_memReady;
                o_ctrl.pcWr    = i_memReady;
            end
            STATE_W'(S_DECODE): begin
                o_ctrl.aluSrcB   = SRCB_IMM_SH2;
                o_ctrl.illegalOp = ~i_legal;
            end
            STATE_W'(S_MEMADR): begin
                o_ctrl.aluSrcA = 1'b1;
                o_ctrl.aluSrcB = SRCB_IMM;
            end
            STATE_W'(S_MEMRD): begin
                o_ctrl.memRd = 1'b1;
                o_ctrl.iord  = 1'b1;
            end
            STATE_W'(S_MEMWB): begin
                o_ctrl.regWr     = 1'b1;
                o_ctrl.memToReg  = 1'b1;
                o_ctrl.instrDone = 1'b1;
            end
            STATE_W'(S_MEMWR): begin
                // Strobe is held through the wait; retire only on the exit cycle.
                o_ctrl.memWr     = 1'b1;
                o_ctrl.iord      = 1'b1;
                o_ctrl.instrDone = i_memReady;
            end
            STATE_W'(S_EXEC): begin
                o_ctrl.aluSrcA = 1'b1;
                o_ctrl.aluOp   = ALU_FUNCT;
            end
            STATE_W'(S_RWB): begin
                o_ctrl.regWr     = 1'b1;
                o_ctrl.regDst    = 1'b1;
                o_ctrl.instrDone = 1'b1;
            end
            STATE_W'(S_BRANCH): begin
                o_ctrl.aluSrcA   = 1'b1;
                o_ctrl.aluOp     = ALU_SUB;
                o_ctrl.pcSrc     = PC_ALUOUT;
                o_ctrl.pcWrCond  = 1'b1;
                o_ctrl.branchNe  = i_isBne;
                o_ctrl.instrDone = 1'b1;
            end
            STATE_W'(S_JUMP): begin
                o_ctrl.pcWr      = 1'b1;
                o_ctrl.pcSrc     = PC_JUMP;
                o_ctrl.instrDone = 1'b1;
            end
            STATE_W'(S_ADDIEX): begin
                o_ctrl.aluSrcA = 1'b1;
                o_ctrl.aluSrcB = SRCB_IMM;
                o_ctrl.aluOp   = ALU_ADD;
            end
            STATE_W'(S_ADDIWB): begin
                o_ctrl.regWr     = 1'b1;
                o_ctrl.instrDone = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mcu_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mcu_fsm : multicycle MIPS main control unit with its own state reg   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mcu_fsm
    import mcu_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int EN_ADDI       = 1,
    parameter int EN_BNE        = 1,
    parameter int STATE_W       = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,
    mcu_fsm_if.master  bus
);

    logic [STATE_W-1:0] r_state;
    logic               r_isStore;
    logic               r_isBne;
    logic               w_memReady;
    logic               w_legal;
    ctrl_t              w_ctrl;

    assign w_memReady = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;
    assign w_legal    = op_legal(bus.op_code, EN_ADDI != 0, EN_BNE != 0);

    // The opcode is only looked at in DECODE; later states use the captured flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= STATE_W'(S_FETCH);
            r_isStore <= 1'b0;
            r_isBne   <= 1'b0;
        end else begin
            case (r_state)
                STATE_W'(S_FETCH): begin
                    if (w_memReady) r_state <= STATE_W'(S_DECODE);
                end
                STATE_W'(S_DECODE): begin
                    r_isStore <= (bus.op_code == OP_SW);
                    r_isBne   <= (bus.op_code == OP_BNE);
                    if (!w_legal) begin
                        r_state <= STATE_W'(S_FETCH);
                    end else begin
                        case (bus.op_code)
                            OP_R:          r_state <= STATE_W'(S_EXEC);
                            OP_LW, OP_SW:  r_state <= STATE_W'(S_MEMADR);
                            OP_BEQ, OP_BNE: r_state <= STATE_W'(S_BRANCH);
                            OP_J:          r_state <= STATE_W'(S_JUMP);
                            OP_ADDI:       r_state <= STATE_W'(S_ADDIEX);
                            default:       r_state <= STATE_W'(S_FETCH);
                        endcase
                    end
                end
                STATE_W'(S_MEMADR): begin
                    r_state <= r_isStore ? STATE_W'(S_MEMWR) : STATE_W'(S_MEMRD);
                end
                STATE_W'(S_MEMRD): begin
                    if (w_memReady) r_state <= STATE_W'(S_MEMWB);
                end
                STATE_W'(S_MEMWR): begin
                    if (w_memReady) r_state <= STATE_W'(S_FETCH);
                end
                STATE_W'(S_EXEC):   r_state <= STATE_W'(S_RWB);
                STATE_W'(S_ADDIEX): r_state <= STATE_W'(S_ADDIWB);
                default:            r_state <= STATE_W'(S_FETCH);
            endcase
        end
    end

    mcu_out_decode #(
        .STATE_W (STATE_W)
    ) u_outDecode (
        .i_state    (r_state),
        .i_memReady (w_memReady),
        .i_legal    (w_legal),
        .i_isBne    (r_isBne),
        .o_ctrl     (w_ctrl)
    );

    assign bus.pc_wr      = w_ctrl.pcWr;
    assign bus.pc_wr_cond = w_ctrl.pcWrCond;
    assign bus.branch_ne  = w_ctrl.branchNe;
    assign bus.iord       = w_ctrl.iord;
    assign bus.mem_rd     = w_ctrl.memRd;
    assign bus.mem_wr     = w_ctrl.memWr;
    assign bus.ir_wr      = w_ctrl.irWr;
    assign bus.mem_to_reg = w_ctrl.memToReg;
    assign bus.pc_src     = w_ctrl.pcSrc;
    assign bus.alu_op     = w_ctrl.aluOp;
    assign bus.alu_src_b  = w_ctrl.aluSrcB;
    assign bus.alu_src_a  = w_ctrl.aluSrcA;
    assign bus.reg_wr     = w_ctrl.regWr;
    assign bus.reg_dst    = w_ctrl.regDst;
    assign bus.illegal_op = w_ctrl.illegalOp;
    assign bus.instr_done = w_ctrl.instrDone;
    assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mcu_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mcu_fsm : scoreboard bench, default build and an EN_ADDI=0 build  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mcu_fsm;

    // Bench-local control vector layout (MSB first):
    // pc_wr pc_wr_cond branch_ne iord mem_rd mem_wr ir_wr mem_to_reg
    // pc_src[1:0] alu_op[1:0] alu_src_b[1:0] alu_src_a reg_wr reg_dst illegal_op instr_done
    localparam logic [18:0] c_PCWR   = 19'h1 << 18;
    localparam logic [18:0] c_PCWC   = 19'h1 << 17;
    localparam logic [18:0] c_BNE    = 19'h1 << 16;
    localparam logic [18:0] c_IORD   = 19'h1 << 15;
    localparam logic [18:0] c_MRD    = 19'h1 << 14;
    localparam logic [18:0] c_MWR    = 19'h1 << 13;
    localparam logic [18:0] c_IRWR   = 19'h1 << 12;
    localparam logic [18:0] c_M2R    = 19'h1 << 11;
    localparam logic [18:0] c_PCS10  = 19'h1 << 10;
    localparam logic [18:0] c_PCS01  = 19'h1 << 9;
    localparam logic [18:0] c_ALUFN  = 19'h1 << 8;
    localparam logic [18:0] c_ALUSUB = 19'h1 << 7;
    localparam logic [18:0] c_SRCB10 = 19'h1 << 6;
    localparam logic [18:0] c_SRCB01 = 19'h1 << 5;
    localparam logic [18:0] c_SRCA   = 19'h1 << 4;
    localparam logic [18:0] c_RWR    = 19'h1 << 3;
    localparam logic [18:0] c_RDST   = 19'h1 << 2;
    localparam logic [18:0] c_ILL    = 19'h1 << 1;
    localparam logic [18:0] c_DONE   = 19'h1;

    localparam logic [18:0] c_F_WAIT  = c_MRD | c_SRCB01;
    localparam logic [18:0] c_F_GO    = c_MRD | c_SRCB01 | c_IRWR | c_PCWR;
    localparam logic [18:0] c_DEC     = c_SRCB10 | c_SRCB01;
    localparam logic [18:0] c_DEC_ILL = c_SRCB10 | c_SRCB01 | c_ILL;
    localparam logic [18:0] c_MADR    = c_SRCA | c_SRCB10;
    localparam logic [18:0] c_MRDS    = c_MRD | c_IORD;
    localparam logic [18:0] c_MWB     = c_RWR | c_M2R | c_DONE;
    localparam logic [18:0] c_MWR_W   = c_MWR | c_IORD;
    localparam logic [18:0] c_MWR_GO  = c_MWR | c_IORD | c_DONE;
    localparam logic [18:0] c_EXEC    = c_SRCA | c_ALUFN;
    localparam logic [18:0] c_RWB     = c_RWR | c_RDST | c_DONE;
    localparam logic [18:0] c_BR_EQ   = c_SRCA | c_ALUSUB | c_PCS01 | c_PCWC | c_DONE;
    localparam logic [18:0] c_BR_NE   = c_BR_EQ | c_BNE;
    localparam logic [18:0] c_JMP     = c_PCWR | c_PCS10 | c_DONE;
    localparam logic [18:0] c_AEX     = c_SRCA | c_SRCB10;
    localparam logic [18:0] c_AWB     = c_RWR | c_DONE;

    localparam logic [5:0] c_R = 6'b000000, c_LW = 6'b100011, c_SW = 6'b101011;
    localparam logic [5:0] c_BEQ = 6'b000100, c_BNEOP = 6'b000101, c_J = 6'b000010;
    localparam logic [5:0] c_ADDI = 6'b001000, c_BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] r_op = 6'd0;
    logic       r_rdy = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         doneA = 0;
    int         doneB = 0;
    logic [22:0] qA[$];
    logic [22:0] qB[$];

    always #5 clk = ~clk;

    mcu_fsm_if #(.STATE_W(4)) busA ();
    mcu_fsm_if #(.STATE_W(4)) busB ();

    assign busA.op_code   = r_op;
    assign busA.mem_ready = r_rdy;
    assign busB.op_code   = r_op;
    assign busB.mem_ready = r_rdy;

    mcu_fsm dutA (.clk(clk), .rst(rst), .bus(busA));
    mcu_fsm #(.EN_ADDI(0)) dutB (.clk(clk), .rst(rst), .bus(busB));

    logic [18:0] w_vecA, w_vecB;
    assign w_vecA = {busA.pc_wr, busA.pc_wr_cond, busA.branch_ne, busA.iord, busA.mem_rd,
                     busA.mem_wr, busA.ir_wr, busA.mem_to_reg, busA.pc_src, busA.alu_op,
                     busA.alu_src_b, busA.alu_src_a, busA.reg_wr, busA.reg_dst,
                     busA.illegal_op, busA.instr_done};
    assign w_vecB = {busB.pc_wr, busB.pc_wr_cond, busB.branch_ne, busB.iord, busB.mem_rd,
                     busB.mem_wr, busB.ir_wr, busB.mem_to_reg, busB.pc_src, busB.alu_op,
                     busB.alu_src_b, busB.alu_src_a, busB.reg_wr, busB.reg_dst,
                     busB.illegal_op, busB.instr_done};

    task automatic chk(input string nm, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Monitor: the controller presents a full output set every cycle.
    always @(negedge clk) begin
        logic [22:0] e;
        if (busA.instr_done === 1'b1) doneA++;
        if (busB.instr_done === 1'b1) doneB++;
        if (qA.size() > 0) begin
            e = qA.pop_front();
            chk("A.state", {15'd0, busA.state}, {15'd0, e[22:19]});
            chk("A.ctrl", w_vecA, e[18:0]);
        end
        if (qB.size() > 0) begin
            e = qB.pop_front();
            chk("B.state", {15'd0, busB.state}, {15'd0, e[22:19]});
            chk("B.ctrl", w_vecB, e[18:0]);
        end
    end

    task automatic step2(input logic [5:0] op, input logic rdy, input logic rs,
                         input logic [3:0] sA, input logic [18:0] eA,
                         input logic [3:0] sB, input logic [18:0] eB);
        #1;
        r_op  = op;
        r_rdy = rdy;
        rst   = rs;
        qA.push_back({sA, eA});
        qB.push_back({sB, eB});
        @(posedge clk);
    endtask

    task automatic step(input logic [5:0] op, input logic rdy, input logic [3:0] s, input logic [18:0] e);
        step2(op, rdy, 1'b0, s, e, s, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        // Reset state, FETCH waiting on memory
        step(c_R, 1'b0, 4'd0, c_F_WAIT);
        // R-type
        step(c_R, 1'b1, 4'd0, c_F_GO);
        step(c_R, 1'b1, 4'd1, c_DEC);
        step(c_R, 1'b1, 4'd6, c_EXEC);
        step(c_R, 1'b1, 4'd7, c_RWB);
        // LW with a 3-cycle memory stall
        step(c_LW, 1'b1, 4'd0, c_F_GO);
        step(c_LW, 1'b1, 4'd1, c_DEC);
        step(c_LW, 1'b1, 4'd2, c_MADR);
        for (int i = 0; i < 3; i++) step(c_LW, 1'b0, 4'd3, c_MRDS);
        step(c_LW, 1'b1, 4'd3, c_MRDS);
        step(c_LW, 1'b1, 4'd4, c_MWB);
        // SW with one stall cycle
        step(c_SW, 1'b1, 4'd0, c_F_GO);
        step(c_SW, 1'b1, 4'd1, c_DEC);
        step(c_SW, 1'b1, 4'd2, c_MADR);
        step(c_SW, 1'b0, 4'd5, c_MWR_W);
        step(c_SW, 1'b1, 4'd5, c_MWR_GO);
        // BNE then BEQ
        step(c_BNEOP, 1'b1, 4'd0, c_F_GO);
        step(c_BNEOP, 1'b1, 4'd1, c_DEC);
        step(c_BNEOP, 1'b1, 4'd8, c_BR_NE);
        step(c_BEQ, 1'b1, 4'd0, c_F_GO);
        step(c_BEQ, 1'b1, 4'd1, c_DEC);
        step(c_BEQ, 1'b1, 4'd8, c_BR_EQ);
        // Jump
        step(c_J, 1'b1, 4'd0, c_F_GO);
        step(c_J, 1'b1, 4'd1, c_DEC);
        step(c_J, 1'b1, 4'd9, c_JMP);
        // Illegal opcode
        step(c_BAD, 1'b1, 4'd0, c_F_GO);
        step(c_BAD, 1'b1, 4'd1, c_DEC_ILL);
        step(c_BAD, 1'b0, 4'd0, c_F_WAIT);
        // ADDI: decoded by A, illegal in B (B refetches and rejects it again)
        step(c_ADDI, 1'b1, 4'd0, c_F_GO);
        step2(c_ADDI, 1'b1, 1'b0, 4'd1, c_DEC, 4'd1, c_DEC_ILL);
        step2(c_ADDI, 1'b1, 1'b0, 4'd10, c_AEX, 4'd0, c_F_GO);
        step2(c_ADDI, 1'b1, 1'b0, 4'd11, c_AWB, 4'd1, c_DEC_ILL);
        // Reset in the middle of an LW memory read
        step(c_LW, 1'b1, 4'd0, c_F_GO);
        step(c_LW, 1'b1, 4'd1, c_DEC);
        step(c_LW, 1'b1, 4'd2, c_MADR);
        step2(c_LW, 1'b0, 1'b1, 4'd3, c_MRDS, 4'd3, c_MRDS);
        step(c_LW, 1'b0, 4'd0, c_F_WAIT);
        step(c_LW, 1'b0, 4'd0, c_F_WAIT);
        @(negedge clk);
        #1;
        chk("A.queue_drained", 19'(qA.size()), 19'd0);
        chk("B.queue_drained", 19'(qB.size()), 19'd0);
        chk("A.retire_count", 19'(doneA), 19'd7);
        chk("B.retire_count", 19'(doneB), 19'd6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
